// File: rtl/regfile_mp.sv
// Parametrised register file: 2**AW x W, two registered read ports, one write port with
// ALU/memory writeback mux, r0 hard-wired to zero, and a pending-load hazard scoreboard.
// Build option: define REGF_FWD_EN to forward same-edge write data into read captures.
module regfile_mp #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          regwrite,
    input  logic          memtoreg,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  alu_wd,
    input  logic [W-1:0]  mem_wd,
    input  logic          pend_set,
    input  logic [AW-1:0] pend_addr,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2,
    output logic          rd_valid,
    output logic          hazard
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]     r_regs [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [W-1:0]     r_rd1;
    logic [W-1:0]     r_rd2;
    logic             r_rd_valid;
    logic             r_hazard;

    logic [W-1:0]     w_wd;
    logic [W-1:0]     w_val1;
    logic [W-1:0]     w_val2;
    logic             w_hazard;
    logic [DEPTH-1:0] w_pend_nxt;

    // Writeback mux
    assign w_wd = memtoreg ? mem_wd : alu_wd;

    // Read value for one address: r0 reads zero, optional forwarding of this edge's write
    function automatic logic [W-1:0] read_value(input logic [AW-1:0] addr);
        logic [W-1:0] val;
        val = r_regs[addr];
`ifdef REGF_FWD_EN
        if (regwrite && (wa == addr)) begin
            val = w_wd;
        end
`endif
        if (addr == '0) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        w_val1 = read_value(ra1);
        w_val2 = read_value(ra2);
    end

    // Hazard uses the scoreboard as it stands before this edge's update
    assign w_hazard = r_pend[ra1] | r_pend[ra2];

    // Scoreboard next state: a load completing clears, a newly issued load sets (set wins)
    always_comb begin
        w_pend_nxt = r_pend;
        if (regwrite && memtoreg) begin
            w_pend_nxt[wa] = 1'b0;
        end
        if (pend_set && (pend_addr != '0)) begin
            w_pend_nxt[pend_addr] = 1'b1;
        end
    end

    // Register array write port; address 0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else if (regwrite && (wa != '0)) begin
            r_regs[wa] <= w_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Read capture: data holds while idle, valid/hazard drop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_rd_valid <= 1'b0;
            r_hazard   <= 1'b0;
        end else if (re) begin
            r_rd1      <= w_val1;
            r_rd2      <= w_val2;
            r_rd_valid <= 1'b1;
            r_hazard   <= w_hazard;
        end else begin
            r_rd_valid <= 1'b0;
            r_hazard   <= 1'b0;
        end
    end

    assign rd1      = r_rd1;
    assign rd2      = r_rd2;
    assign rd_valid = r_rd_valid;
    assign hazard   = r_hazard;

endmodule
